// File: rtl/gray_updown_counter.sv
// Parametrised up/down reflected-Gray counter with enable, parallel load, wrap/saturate
// ends and registered terminal-count and boundary flags. Optional step prescaler: PRESCALE_EN.
module gray_updown_counter #(
    parameter int WIDTH     = 3,
    parameter int MODE_WRAP = 1,
    parameter int RESET_IDX = 0,
    parameter int PRESCALE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_idx,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] idx_out,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] IDX_MAX   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] IDX_MIN   = '0;
    localparam logic [WIDTH-1:0] RST_IDX   = RESET_IDX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_GRAY  = RST_IDX ^ (RST_IDX >> 1);
    localparam logic             RST_MAX   = (RST_IDX == IDX_MAX);
    localparam logic             RST_MIN   = (RST_IDX == IDX_MIN);

    logic [WIDTH-1:0] idx_q,    idx_d;
    logic [WIDTH-1:0] gray_q,   gray_d;
    logic             tc_q,     tc_d;
    logic             at_max_q, at_max_d;
    logic             at_min_q, at_min_d;
    logic             step_fire;

`ifdef PRESCALE_EN
    localparam int              PSC_W    = $clog2(PRESCALE);
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    logic [PSC_W-1:0] psc_q, psc_d;

    // The prescaler only advances on enabled cycles; load restarts the spacing.
    always_comb begin
        psc_d     = psc_q;
        step_fire = 1'b0;
        if (load) begin
            psc_d = '0;
        end else if (en) begin
            if (psc_q == PSC_LAST) begin
                psc_d     = '0;
                step_fire = 1'b1;
            end else begin
                psc_d = psc_q + 1'b1;
            end
        end
    end
`else
    always_comb begin
        step_fire = en;
    end
`endif

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        idx_d = idx_q;
        tc_d  = 1'b0;
        if (load) begin
            idx_d = load_idx;
        end else if (step_fire) begin
            if (!dir) begin
                if (idx_q == IDX_MAX) begin
                    tc_d  = 1'b1;
                    idx_d = (MODE_WRAP != 0) ? IDX_MIN : idx_q;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                if (idx_q == IDX_MIN) begin
                    tc_d  = 1'b1;
                    idx_d = (MODE_WRAP != 0) ? IDX_MAX : idx_q;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
        end
        // Gray code and flags come from the next index, so all outputs land on the same edge.
        gray_d   = idx_d ^ (idx_d >> 1);
        at_max_d = (idx_d == IDX_MAX);
        at_min_d = (idx_d == IDX_MIN);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= RST_IDX;
            gray_q   <= RST_GRAY;
            tc_q     <= 1'b0;
            at_max_q <= RST_MAX;
            at_min_q <= RST_MIN;
`ifdef PRESCALE_EN
            psc_q    <= '0;
`endif
        end else begin
            idx_q    <= idx_d;
            gray_q   <= gray_d;
            tc_q     <= tc_d;
            at_max_q <= at_max_d;
            at_min_q <= at_min_d;
`ifdef PRESCALE_EN
            psc_q    <= psc_d;
`endif
        end
    end

    assign gray_out = gray_q;
    assign idx_out  = idx_q;
    assign tc       = tc_q;
    assign at_max   = at_max_q;
    assign at_min   = at_min_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed bench for gray_updown_counter: a wrap instance (RESET_IDX=0) and a saturate
// instance (RESET_IDX=2) share the same stimulus; expectations are hand-computed.
module tb_gray_updown_counter;

    logic       clk = 1'b0;
    logic       rst, en, dir, load;
    logic [2:0] load_idx;

    logic [2:0] w_gray, w_idx, s_gray, s_idx;
    logic       w_tc, w_max, w_min, s_tc, s_max, s_min;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gray_updown_counter #(.WIDTH(3), .MODE_WRAP(1), .RESET_IDX(0), .PRESCALE(4)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_idx(load_idx),
        .gray_out(w_gray), .idx_out(w_idx), .tc(w_tc), .at_max(w_max), .at_min(w_min)
    );

    gray_updown_counter #(.WIDTH(3), .MODE_WRAP(0), .RESET_IDX(2), .PRESCALE(4)) u_sat (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_idx(load_idx),
        .gray_out(s_gray), .idx_out(s_idx), .tc(s_tc), .at_max(s_max), .at_min(s_min)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
    task automatic cyc(input logic r, input logic e, input logic d, input logic l, input logic [2:0] li);
        @(negedge clk);
        rst = r; en = e; dir = d; load = l; load_idx = li;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input string tag, input logic [2:0] idx, input logic [2:0] gray, input logic t);
        check({tag, ".w_idx"}, 32'(w_idx), 32'(idx));
        check({tag, ".w_gray"}, 32'(w_gray), 32'(gray));
        check({tag, ".w_tc"}, 32'(w_tc), 32'(t));
    endtask

    task automatic chk_s(input string tag, input logic [2:0] idx, input logic [2:0] gray, input logic t);
        check({tag, ".s_idx"}, 32'(s_idx), 32'(idx));
        check({tag, ".s_gray"}, 32'(s_gray), 32'(gray));
        check({tag, ".s_tc"}, 32'(s_tc), 32'(t));
    endtask

    logic [2:0] up_gray [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    logic [2:0] sat_idx [8] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7};
    logic [2:0] prev_gray;

    initial begin
        rst = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; load_idx = 3'd0;

        // Reset state of both instances
        cyc(1, 0, 0, 0, 3'd0);
        chk_w("rst", 3'd0, 3'b000, 1'b0);
        check("rst.w_min", 32'(w_min), 32'd1);
        check("rst.w_max", 32'(w_max), 32'd0);
        chk_s("rst", 3'd2, 3'b011, 1'b0);
        check("rst.s_min", 32'(s_min), 32'd0);
        check("rst.s_max", 32'(s_max), 32'd0);

`ifndef PRESCALE_EN
        // Eight up steps: full Gray cycle with wrap, tc only after 100->000
        prev_gray = w_gray;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, 0, 3'd0);
            check($sformatf("up%0d.w_gray", i), 32'(w_gray), 32'(up_gray[i]));
            check($sformatf("up%0d.w_tc", i), 32'(w_tc), (i == 7) ? 32'd1 : 32'd0);
            check($sformatf("up%0d.onebit", i), 32'($countones(w_gray ^ prev_gray)), 32'd1);
            check($sformatf("up%0d.s_idx", i), 32'(s_idx), 32'(sat_idx[i]));
            check($sformatf("up%0d.s_tc", i), 32'(s_tc), (i >= 5) ? 32'd1 : 32'd0);
            prev_gray = w_gray;
        end
        check("up.w_min", 32'(w_min), 32'd1);
        check("up.s_max", 32'(s_max), 32'd1);

        // Down from 0 wraps to 7 with tc; next down gives 6 without tc; en=0 holds
        cyc(0, 1, 1, 0, 3'd0);
        chk_w("dn_wrap", 3'd7, 3'b100, 1'b1);
        check("dn_wrap.w_max", 32'(w_max), 32'd1);
        cyc(0, 1, 1, 0, 3'd0);
        chk_w("dn_6", 3'd6, 3'b101, 1'b0);
        cyc(0, 0, 1, 0, 3'd0);
        chk_w("hold", 3'd6, 3'b101, 1'b0);

        // Saturate: load 6, three up steps -> 7 held, tc on the 2nd and 3rd step
        cyc(0, 0, 0, 1, 3'd6);
        chk_s("sat_ld", 3'd6, 3'b101, 1'b0);
        cyc(0, 1, 0, 0, 3'd0);
        chk_s("sat_up1", 3'd7, 3'b100, 1'b0);
        check("sat_up1.s_max", 32'(s_max), 32'd1);
        cyc(0, 1, 0, 0, 3'd0);
        chk_s("sat_up2", 3'd7, 3'b100, 1'b1);
        cyc(0, 1, 0, 0, 3'd0);
        chk_s("sat_up3", 3'd7, 3'b100, 1'b1);
        cyc(0, 0, 0, 0, 3'd0);
        check("sat_idle.s_tc", 32'(s_tc), 32'd0);

        // Saturate: blocked down at 0 holds and pulses tc
        cyc(0, 0, 0, 1, 3'd0);
        cyc(0, 1, 1, 0, 3'd0);
        chk_s("sat_dn0", 3'd0, 3'b000, 1'b1);
        check("sat_dn0.s_min", 32'(s_min), 32'd1);

        // Load wins over en/dir; next up step continues from the loaded index
        cyc(0, 1, 0, 1, 3'd5);
        chk_w("ld_en", 3'd5, 3'b111, 1'b0);
        cyc(0, 1, 0, 0, 3'd0);
        chk_w("ld_next", 3'd6, 3'b101, 1'b0);

        // Load onto max with en=1, dir=0 must not raise tc
        cyc(0, 1, 0, 1, 3'd7);
        chk_w("ld_max", 3'd7, 3'b100, 1'b0);

        // Reset overrides load and en; counting resumes from RESET_IDX
        cyc(0, 0, 0, 1, 3'd3);
        cyc(1, 1, 0, 1, 3'd6);
        chk_s("rst_ovr", 3'd2, 3'b011, 1'b0);
        chk_w("rst_ovr", 3'd0, 3'b000, 1'b0);
        cyc(0, 1, 0, 0, 3'd0);
        chk_s("rst_resume", 3'd3, 3'b010, 1'b0);
`else
        // Prescaled stepping: one index step per four enabled cycles
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 3'd0);
            check($sformatf("psc_a%0d.w_idx", i), 32'(w_idx), 32'd0);
        end
        cyc(0, 1, 0, 0, 3'd0);
        chk_w("psc_step1", 3'd1, 3'b001, 1'b0);

        // Two enabled cycles, then en=0 freezes the prescaler for three cycles
        cyc(0, 1, 0, 0, 3'd0);
        cyc(0, 1, 0, 0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 3'd0);
            check($sformatf("psc_frz%0d.w_idx", i), 32'(w_idx), 32'd1);
        end
        cyc(0, 1, 0, 0, 3'd0);
        check("psc_b3.w_idx", 32'(w_idx), 32'd1);
        cyc(0, 1, 0, 0, 3'd0);
        chk_w("psc_step2", 3'd2, 3'b011, 1'b0);

        // Load restarts the spacing
        cyc(0, 1, 0, 0, 3'd0);
        cyc(0, 1, 0, 1, 3'd5);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 3'd0);
            check($sformatf("psc_ld%0d.w_idx", i), 32'(w_idx), 32'd5);
        end
        cyc(0, 1, 0, 0, 3'd0);
        chk_w("psc_step3", 3'd6, 3'b101, 1'b0);

        // tc only on the actual wrapping step
        cyc(0, 0, 0, 1, 3'd7);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 3'd0);
            check($sformatf("psc_tc%0d.w_tc", i), 32'(w_tc), 32'd0);
        end
        cyc(0, 1, 0, 0, 3'd0);
        chk_w("psc_wrap", 3'd0, 3'b000, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
